// File: rtl/four_digit_led_driver_text_button.sv
// Purpose: scrolls a 16-char hex message across a 4-digit common-anode 7-seg display; right button steps the window left.
// Latency: all outputs registered; a new ptr shows on the lit digit two edges after the step pulse.
// Backpressure: none; free-running scan, button presses are never queued. Optional filter macro: LED_TEXT_DEBOUNCE_EN.
module four_digit_led_driver_text_button #(
    parameter int          REFRESH_CYCLES  = 16,
    parameter int          DEBOUNCE_CYCLES = 32,
    parameter logic [63:0] MESSAGE         = 64'h0123456789ABCDEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btnr,
    output logic an3,
    output logic an2,
    output logic an1,
    output logic an0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic dp
);

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    // Reject configurations the scan and filter cannot honour.
    if (REFRESH_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("four_digit_led_driver_text_button: REFRESH_CYCLES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [RW-1:0] scnt;
    logic [1:0]    sel;     // 0 = an3 (leftmost) ... 3 = an0
    logic [3:0]    ptr;
    logic          sync1;
    logic          sync2;
    logic          acc;     // accepted (clean) button level
    logic          step;
    logic [3:0]    idx;
    logic [3:0]    chr;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    // Active-low {a..g} pattern for one hex character.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Digit scan: hold each selector value for REFRESH_CYCLES cycles, then rotate.
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt <= '0;
            sel  <= 2'd0;
        end else if (scnt == RW'(REFRESH_CYCLES - 1)) begin
            scnt <= '0;
            sel  <= sel + 2'd1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btnr;
            sync2 <= sync1;
        end
    end

`ifdef LED_TEXT_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] dcnt;

    // Debounce: count while the input disagrees with the accepted level; flip after DEBOUNCE_CYCLES and pulse on a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
            acc  <= 1'b0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (sync2 == acc) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEBOUNCE_CYCLES)) begin
                dcnt <= '0;
                acc  <= sync2;
                step <= sync2;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end
`else
    // No filter: accepted level tracks the synchronizer; pulse on its first high cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= 1'b0;
            step <= 1'b0;
        end else begin
            acc  <= sync2;
            step <= sync2 & ~acc;
        end
    end
`endif

    // Message pointer: one step per accepted press, wrapping 15 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 4'd0;
        end else if (step) begin
            ptr <= ptr + 4'd1;
        end
    end

    // Character for the selected digit; char[0] sits in the top nibble, so the bit offset is (15-idx)*4.
    always_comb begin
        idx = ptr + {2'b00, sel};
        chr = MESSAGE[{~idx, 2'b00} +: 4];
    end

    // Registered pins: anode and segments always update together from the same selector.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= ~(4'b1000 >> sel);
            seg_q <= hex7(chr);
        end
    end

    assign {an3, an2, an1, an0} = an_q;
    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp = 1'b1;

endmodule

// File: tb/tb_four_digit_led_driver_text_button.sv
// Purpose: directed self-checking bench for four_digit_led_driver_text_button.
// Latency: checks exact scan timing and press-to-display latency cycle by cycle.
// Backpressure: n/a; bench drives the button and samples pins on the falling edge.
module tb_four_digit_led_driver_text_button;

    localparam int R = 16;
    localparam int D = 32;

    logic clk = 1'b0;
    logic reset;
    logic btnr;
    logic an3, an2, an1, an0;
    logic a, b, c, d, e, f, g, dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] dec [16];
    logic [3:0] an_tab [4];

    typedef struct {
        bit rst;
        int hold;
        int gap;
        int exp_ptr;
    } vec_t;
    vec_t tbl [20];
    int   ntbl;

    wire [3:0] an  = {an3, an2, an1, an0};
    wire [6:0] seg = {a, b, c, d, e, f, g};

    four_digit_led_driver_text_button #(
        .REFRESH_CYCLES (R),
        .DEBOUNCE_CYCLES(D),
        .MESSAGE        (64'h0123456789ABCDEF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btnr (btnr),
        .an3  (an3),
        .an2  (an2),
        .an1  (an1),
        .an0  (an0),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .e    (e),
        .f    (f),
        .g    (g),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        btnr = 1'b1;
        repeat (hold) tick();
        btnr = 1'b0;
        repeat (gap) tick();
    endtask

    // Watch one full frame and check every digit shows char[p+j]; exactly one anode low each cycle.
    task automatic check_frame(input int p, input string name);
        logic [6:0] seen [4];
        int bad;
        bad = 0;
        for (int j = 0; j < 4; j++) seen[j] = 'x;
        for (int k = 0; k < 4 * R; k++) begin
            tick();
            case (an)
                4'b0111: seen[0] = seg;
                4'b1011: seen[1] = seg;
                4'b1101: seen[2] = seg;
                4'b1110: seen[3] = seg;
                default: bad++;
            endcase
            if (dp !== 1'b1) bad++;
        end
        chk($sformatf("%s_onehot", name), 32'(bad), 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s_d%0d", name, j), 32'(seen[j]), 32'(dec[(p + j) % 16]));
    endtask

    initial begin
        int lat;
        int nb;
        int cedge;
        int sel;
        int p;
        int glitch_ptr;

        dec = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        an_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

`ifdef LED_TEXT_DEBOUNCE_EN
        lat        = D + 4;
        glitch_ptr = 3;
`else
        lat        = 4;
        glitch_ptr = 4;
`endif

        // Press-sequence table, starting from ptr = 1 after the first held press.
        tbl[0] = '{1'b0, 370, 30, 2};
        tbl[1] = '{1'b0, 110, 520, 3};
        tbl[2] = '{1'b0, 10, 100, glitch_ptr};
        tbl[3] = '{1'b1, 60, 60, 1};
        for (int i = 2; i <= 16; i++) tbl[i + 2] = '{1'b0, 60, 60, i % 16};
        ntbl = 19;

        // Reset held 300 cycles, with the button wiggled in the middle.
        reset = 1'b1;
        btnr  = 1'b0;
        repeat (3) tick();
        chk("rst_early", 32'({an, seg, dp}), 32'({4'b1111, 7'b1111111, 1'b1}));
        repeat (100) tick();
        btnr = 1'b1;
        repeat (100) tick();
        chk("rst_btn_held", 32'({an, seg, dp}), 32'({4'b1111, 7'b1111111, 1'b1}));
        btnr = 1'b0;
        repeat (97) tick();
        chk("rst_late", 32'({an, seg, dp}), 32'({4'b1111, 7'b1111111, 1'b1}));
        reset = 1'b0;

        // Cycle-exact scan after reset plus one press timed so the new ptr lands at edge 70 on an3.
        cedge = 70;
        nb    = cedge - lat;
        for (int k = 1; k <= 80; k++) begin
            tick();
            sel = ((k - 1) / R) % 4;
            p   = (k >= cedge) ? 1 : 0;
            chk($sformatf("scan_k%0d", k), 32'({an, seg, dp}),
                32'({an_tab[sel], dec[(p + sel) % 16], 1'b1}));
            if (k == nb - 1) btnr = 1'b1;
        end
        repeat (400 - (81 - nb)) tick();
        btnr = 1'b0;
        repeat (100) tick();
        check_frame(1, "hold400");

        // Table-driven presses: multiple lengths, a short glitch, and a 16-press wrap from reset.
        for (int i = 0; i < ntbl; i++) begin
            if (tbl[i].rst) begin
                reset = 1'b1;
                repeat (5) tick();
                reset = 1'b0;
            end
            press(tbl[i].hold, tbl[i].gap);
            check_frame(tbl[i].exp_ptr, $sformatf("vec%0d", i));
        end

        // Reset 50 cycles into a held press; the still-held button must re-qualify as one new press.
        btnr = 1'b1;
        repeat (50) tick();
        reset = 1'b1;
        tick();
        chk("midpress_rst", 32'({an, seg, dp}), 32'({4'b1111, 7'b1111111, 1'b1}));
        repeat (20) tick();
        chk("midpress_rst_hold", 32'({an, seg, dp}), 32'({4'b1111, 7'b1111111, 1'b1}));
        reset = 1'b0;
        tick();
        chk("midpress_first", 32'({an, seg, dp}), 32'({4'b0111, dec[0], 1'b1}));
        repeat (199) tick();
        btnr = 1'b0;
        repeat (100) tick();
        check_frame(1, "midpress_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_digit_led_driver_text_button.md
# four_digit_led_driver_text_button

Drives a four-digit, common-anode seven-segment display with a 16-character hex message, showing four consecutive characters at a time. Each debounced press of the right push-button scrolls the message one character to the left, wrapping after the last character. It sits between the board's push-button input and the display pins, with one system clock and no other interfaces.

## Interface
Parameters:
- REFRESH_CYCLES, 16: clock cycles each digit stays lit per scan step; ≥ 2.
- DEBOUNCE_CYCLES, 32: consecutive stable cycles needed to accept a button level change; ≥ 1.
- MESSAGE, 64'h0123456789ABCDEF: sixteen 4-bit characters; char[0] = bits 63:60, char[15] = bits 3:0.

Ports:
- One clock; reset is synchronous and active-high.
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- btnr, input, 1: raw, asynchronous, bouncy scroll button; active-high.
- an3, an2, an1, an0, output, 1 each: digit anodes, active-low; an3 = leftmost.
- a, b, c, d, e, f, g, output, 1 each: segment cathodes, active-low, shared by all digits.
- dp, output, 1: decimal point, active-low; always 1 (off).

## Operation
- Pointer ptr (4 bits): index of the character shown on an3. an2 shows char[ptr+1], an1 shows char[ptr+2], an0 shows char[ptr+3]. All index sums wrap mod 16.
- Scan: a digit selector rotates an3 → an2 → an1 → an0 → an3. Exactly one anode is low at any time after reset.
- Decoder: standard hex to active-low {a..g} mapping.
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111.
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Button path:
  - Two-flop synchronizer.
  - Debounce filter: a counter runs while the synchronized level differs from the accepted level and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the accepted level flips.
  - A rising edge of the accepted level produces a one-cycle step pulse. The step pulse increments ptr, wrapping 15 → 0.
  - Holding the button produces exactly one step. Release is filtered the same way and produces no step.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Reset values: ptr = 0; scan counter = 0; selector = an3; debounce state cleared with accepted level 0; an3..an0 = 1111; a..g = 1111111; dp = 1.

## Timing
- All outputs are registered.
- Clock edge 1 after reset deasserts: an3 = 0 and segments = decode(char[ptr]).
- Each digit stays selected for exactly REFRESH_CYCLES cycles, so a full frame is 4·REFRESH_CYCLES cycles.
- Segments always change on the same edge as the anodes, or one cycle after a ptr change. A non-selected digit's pattern is never shown.
- Press latency: btnr high, sampled at edge N, causes the step pulse at edge N+2+DEBOUNCE_CYCLES. ptr increments on the following edge. The lit digit's segments reflect the new ptr one edge later.
- ptr increments at most once per press, independent of scan position. A step occurring mid-digit updates that digit immediately (next edge); no wait for frame boundary.
- Reset asserted mid-press or mid-scan: the next edge returns everything to reset values. A button still held when reset deasserts must first pass through the filter; it is accepted as a new press after DEBOUNCE_CYCLES.
- While reset is high, btnr is ignored.

## Configuration
- Macro: LED_TEXT_DEBOUNCE_EN.
- Defined: debounce filter as described above.
- Not defined: the filter is removed. The accepted level equals the synchronizer output, so the step pulse fires on the first synchronized high cycle (latency N+2). Glitches then produce extra steps. DEBOUNCE_CYCLES is unused.

## Test plan
- Reset held 300 cycles with btnr = 0:
  - during reset: anodes 1111, segments 1111111, dp 1;
  - after release: an3 low showing 0 (0000001), then an2 showing 1 after 16 cycles, an1 showing 2, an0 showing 3, then an3 again.
- btnr high for 400 cycles: ptr becomes 1 exactly once; an3 shows 1 (1001111), an0 shows 4 (1001100).
- Three presses of 400, 370 and 110 cycles separated by 30-520 cycle gaps: ptr = 3; digits show 3, 4, 5, 6.
- btnr glitch of 10 cycles (< DEBOUNCE_CYCLES): ptr unchanged. With LED_TEXT_DEBOUNCE_EN undefined: ptr increments once.
- 16 clean presses from reset: ptr wraps to 0. After 13 presses, digits show d, E, F, 0, proving index wrap.
- Reset asserted 50 cycles into a held press: all outputs return to reset values next edge; no step is taken during reset.
